// File: rtl/filter_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filter_arbiter_pkg
// Purpose  : Pair-buffer word layout shared by the filters, their pair
//            buffers and the filter arbiter.
//            Word layout, MSB to LSB: {ref_id, nbr_id, r2, dz, dy, dx}.
// Revision : 1.0 - initial release
// ============================================================================
package filter_arbiter_pkg;

  localparam int DEF_DATA_WIDTH        = 32;
  localparam int DEF_PARTICLE_ID_WIDTH = 20;

  // Width of one buffer word for a given data / particle-ID width.
  function automatic int pair_width(input int dw, input int idw);
    return 2 * idw + 4 * dw;
  endfunction

  // Field LSB offsets inside a buffer word; dx sits in the LSBs.
  function automatic int dx_lsb(input int dw);
    return 0 * dw;
  endfunction

  function automatic int dy_lsb(input int dw);
    return 1 * dw;
  endfunction

  function automatic int dz_lsb(input int dw);
    return 2 * dw;
  endfunction

  function automatic int r2_lsb(input int dw);
    return 3 * dw;
  endfunction

  function automatic int nbr_id_lsb(input int dw);
    return 4 * dw;
  endfunction

  function automatic int ref_id_lsb(input int dw, input int idw);
    return 4 * dw + idw;
  endfunction

  // Offsets for the default configuration (32-bit data, 20-bit IDs).
  localparam int PAIR_WIDTH = pair_width(DEF_DATA_WIDTH, DEF_PARTICLE_ID_WIDTH);
  localparam int DX_LSB     = dx_lsb(DEF_DATA_WIDTH);
  localparam int DY_LSB     = dy_lsb(DEF_DATA_WIDTH);
  localparam int DZ_LSB     = dz_lsb(DEF_DATA_WIDTH);
  localparam int R2_LSB     = r2_lsb(DEF_DATA_WIDTH);
  localparam int NBR_ID_LSB = nbr_id_lsb(DEF_DATA_WIDTH);
  localparam int REF_ID_LSB = ref_id_lsb(DEF_DATA_WIDTH, DEF_PARTICLE_ID_WIDTH);

endpackage
`default_nettype wire

// File: rtl/filter_arbiter_rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_select
// Purpose  : Combinational round-robin first-one finder. Searches the
//            request vector starting one above last_grant, wrapping around,
//            and returns the winner as one-hot, as an index and as a flag.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_select
  import filter_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  int w_cand;

  // Walk the N candidates in priority order; the first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    w_cand    = 0;
    for (int off = 1; off <= N; off++) begin
      w_cand = (int'(last_grant) + off) % N;
      for (int i = 0; i < N; i++) begin
        if (!any_grant && (i == w_cand) && req[i]) begin
          any_grant = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/filter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : filter_arbiter
// Purpose  : Round-robin read-side arbiter over the per-filter pair buffers.
//            Pops one non-empty buffer per cycle and forwards the captured
//            pair, with a valid strobe, to the shared force pipeline.
//            Grant at cycle t -> buffer q at t+1 -> out_valid at t+2.
// Revision : 1.0 - initial release
// ============================================================================
module filter_arbiter
  import filter_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int PARTICLE_ID_WIDTH = DEF_PARTICLE_ID_WIDTH,
  parameter int NUM_FILTER        = 4,
  parameter int FILTER_ID_WIDTH   = 2,
  parameter int PAIR_WIDTH        = pair_width(DATA_WIDTH, PARTICLE_ID_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_FILTER-1:0]            filter_pair_available,
  input  logic [NUM_FILTER*PAIR_WIDTH-1:0] filter_pair_data,
  output logic [NUM_FILTER-1:0]            filter_sel,
  input  logic                             force_pipeline_ready,
  output logic [PARTICLE_ID_WIDTH-1:0]     ref_particle_id_out,
  output logic [PARTICLE_ID_WIDTH-1:0]     neighbor_particle_id_out,
  output logic [DATA_WIDTH-1:0]            r2_out,
  output logic [DATA_WIDTH-1:0]            dx_out,
  output logic [DATA_WIDTH-1:0]            dy_out,
  output logic [DATA_WIDTH-1:0]            dz_out,
  output logic [FILTER_ID_WIDTH-1:0]       filter_id_out,
  output logic                             out_valid
);

  localparam int C_DX_LSB     = dx_lsb(DATA_WIDTH);
  localparam int C_DY_LSB     = dy_lsb(DATA_WIDTH);
  localparam int C_DZ_LSB     = dz_lsb(DATA_WIDTH);
  localparam int C_R2_LSB     = r2_lsb(DATA_WIDTH);
  localparam int C_NBR_ID_LSB = nbr_id_lsb(DATA_WIDTH);
  localparam int C_REF_ID_LSB = ref_id_lsb(DATA_WIDTH, PARTICLE_ID_WIDTH);

  logic [FILTER_ID_WIDTH-1:0] r_last_grant;
  logic [FILTER_ID_WIDTH-1:0] r_sel_idx;
  logic                       r_read_pending;
  logic [FILTER_ID_WIDTH-1:0] r_rd_idx;

  logic [NUM_FILTER-1:0]      w_eligible;
  logic [NUM_FILTER-1:0]      w_grant;
  logic [FILTER_ID_WIDTH-1:0] w_grant_idx;
  logic                       w_any_grant;
  logic [PAIR_WIDTH-1:0]      w_rd_word;

  // A buffer popped last cycle may still report non-empty this cycle
  // (one-entry case), so the previous grantee sits this round out.
  assign w_eligible = filter_pair_available & ~filter_sel;

  rr_priority_select #(
    .N     (NUM_FILTER),
    .IDX_W (FILTER_ID_WIDTH)
  ) u_rr_select (
    .req        (w_eligible),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx),
    .any_grant  (w_any_grant)
  );

  // Stage 0: issue at most one rdreq per cycle while downstream is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      filter_sel   <= '0;
      r_last_grant <= FILTER_ID_WIDTH'(NUM_FILTER - 1);
      r_sel_idx    <= '0;
    end else if (force_pipeline_ready && w_any_grant) begin
      filter_sel   <= w_grant;
      r_last_grant <= w_grant_idx;
      r_sel_idx    <= w_grant_idx;
    end else begin
      filter_sel   <= '0;
    end
  end

  // Pending-read stage: the buffer's q becomes valid the cycle after rdreq.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_pending <= 1'b0;
      r_rd_idx       <= '0;
    end else begin
      r_read_pending <= |filter_sel;
      r_rd_idx       <= r_sel_idx;
    end
  end

  // Pick the q of the filter whose read is landing this cycle.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      if (r_rd_idx == FILTER_ID_WIDTH'(i)) begin
        w_rd_word = filter_pair_data[i*PAIR_WIDTH +: PAIR_WIDTH];
      end
    end
  end

  // Stage 1: capture the popped word; data holds when no read lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid                <= 1'b0;
      filter_id_out            <= '0;
      ref_particle_id_out      <= '0;
      neighbor_particle_id_out <= '0;
      r2_out                   <= '0;
      dx_out                   <= '0;
      dy_out                   <= '0;
      dz_out                   <= '0;
    end else if (r_read_pending) begin
      out_valid                <= 1'b1;
      filter_id_out            <= r_rd_idx;
      ref_particle_id_out      <= w_rd_word[C_REF_ID_LSB +: PARTICLE_ID_WIDTH];
      neighbor_particle_id_out <= w_rd_word[C_NBR_ID_LSB +: PARTICLE_ID_WIDTH];
      r2_out                   <= w_rd_word[C_R2_LSB +: DATA_WIDTH];
      dz_out                   <= w_rd_word[C_DZ_LSB +: DATA_WIDTH];
      dy_out                   <= w_rd_word[C_DY_LSB +: DATA_WIDTH];
      dx_out                   <= w_rd_word[C_DX_LSB +: DATA_WIDTH];
    end else begin
      out_valid                <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/filter_arbiter.md
Name: filter_arbiter

Overview:
- Read-side consumer of the per-filter pair buffers inside the filter bank.
- Each cycle it round-robin selects one filter whose buffer is non-empty and pulses that filter's sel (buffer rdreq).
- It captures the popped pair and presents it, with a valid strobe, to the single force pipeline shared by all filters.
- Buffer word layout, MSB to LSB: {ref_particle_id, neighbor_particle_id, r2, dz, dy, dx}.

Parameters:
- DATA_WIDTH, 32, width of r2/dx/dy/dz (IEEE single).
- PARTICLE_ID_WIDTH, 20, width of each particle ID.
- NUM_FILTER, 4, number of filters feeding one force pipeline (2..8).
- FILTER_ID_WIDTH, 2, ceil(log2(NUM_FILTER)), minimum 1.
- PAIR_WIDTH, 2*PARTICLE_ID_WIDTH+4*DATA_WIDTH = 168, width of one buffer word.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- filter_pair_available  in  NUM_FILTER  bit i = filter i buffer non-empty.
- filter_pair_data  in  NUM_FILTER*PAIR_WIDTH  filter i buffer q occupies bits [i*PAIR_WIDTH +: PAIR_WIDTH].
- filter_sel  out  NUM_FILTER  one-hot rdreq to filter buffers.
- force_pipeline_ready  in  1  downstream may accept a pair issued now.
- ref_particle_id_out  out  PARTICLE_ID_WIDTH  selected pair reference ID.
- neighbor_particle_id_out  out  PARTICLE_ID_WIDTH  selected pair neighbour ID.
- r2_out, dx_out, dy_out, dz_out  out  DATA_WIDTH each  selected pair data.
- filter_id_out  out  FILTER_ID_WIDTH  index of the source filter.
- out_valid  out  1  outputs hold a new pair this cycle.

Behaviour:
- Reset: filter_sel=0, out_valid=0, all data outputs 0, filter_id_out=0, grant pointer last_grant=NUM_FILTER-1 (filter 0 has first priority), pending-read stage cleared.
  - Reset mid-operation: an in-flight read is discarded; no out_valid is produced for it.
- Buffer timing: a buffer's q is valid one cycle after rdreq. The empty flag reflects a pop on the cycle after rdreq.
- Stage 0, grant (registered filter_sel):
  - Eligible set = filter_pair_available AND NOT(filter granted in the previous cycle).
  - The exclusion guards against a stale available flag on a one-entry buffer.
  - If force_pipeline_ready=1 and the eligible set is non-empty: grant the first eligible index searching from (last_grant+1) mod NUM_FILTER upward with wrap-around.
    - Drive filter_sel one-hot for exactly one cycle.
    - Update last_grant.
    - Register read_pending=1 and rd_idx.
  - Otherwise filter_sel=0, read_pending=0, last_grant unchanged.
  - Consequence: a single busy filter is granted at most every other cycle. Two or more busy filters give a grant every cycle.
- Stage 1, capture: if read_pending, register the rd_idx slice of filter_pair_data into the outputs, filter_id_out=rd_idx, out_valid=1. Else out_valid=0 and data outputs hold their last values.
- Latency: filter_sel asserted at cycle t gives out_valid at cycle t+2.
- force_pipeline_ready gates only new grants. A read already issued always completes to out_valid, so the downstream must tolerate up to 2 pairs after dropping ready.
- Availability de-asserting in the same cycle as the grant decision: the registered sample governs; stage 0 uses the current-cycle input.
- All-zero available: no grant, pointer frozen.
- The output field split follows the word layout (dx in LSBs).

Decomposition:
- Shared package: PAIR_WIDTH derivation and the field bit offsets of the buffer word (DX_LSB, DY_LSB, DZ_LSB, R2_LSB, NBR_ID_LSB, REF_ID_LSB). The filter, buffer and this arbiter share these.
- One natural sub-module: rr_priority_select, a combinational round-robin first-one finder taking request vector and last_grant, returning one-hot grant, index and any_grant.

Test Plan:
- Reset, then available=4'b0000 for 10 cycles -> filter_sel=0 and out_valid=0 throughout.
- Single pair in filter 2 (available=4'b0100 for one cycle, then 0; q2 = ref 0x00005, nbr 0x00009, r2 0x42C80000) -> filter_sel=4'b0100 once; two cycles later out_valid=1 with ref_particle_id_out=0x00005, neighbor_particle_id_out=0x00009, r2_out=0x42C80000, filter_id_out=2.
- available=4'b1111 held for 8 cycles, ready=1 -> grant order 0,1,2,3,0,1,2,3, one per cycle; out_valid high continuously from cycle 3.
- available=4'b0010 held, ready=1 -> filter_sel alternates 4'b0010 / 0 (every other cycle); out_valid mirrors with 2-cycle lag.
- available=4'b1111, drop ready at cycle 5 -> no filter_sel from cycle 5; out_valid stays high through cycle 6, then 0; raising ready resumes with the filter after last_grant.
- rst asserted the cycle after a grant -> out_valid stays 0 on the following cycle; the first post-reset grant goes to filter 0.
